// File: rtl/sobel_stream_if.sv
// Pixel stream in / gradient stream out bundle for sobel_stream.
// The design takes the slave side; the pixel source / result sink takes the master side.
interface sobel_stream_if #(
   parameter int WORD_SIZE = 8
);
   logic                 sof;
   logic                 in_valid;
   logic [WORD_SIZE-1:0] in_data;
   logic [1:0]           mode;
   logic [WORD_SIZE-1:0] threshold;
   logic                 out_valid;
   logic                 out_sof;
   logic [WORD_SIZE-1:0] out_data;

   modport slave (
      input  sof, in_valid, in_data, mode, threshold,
      output out_valid, out_sof, out_data
   );

   modport master (
      output sof, in_valid, in_data, mode, threshold,
      input  out_valid, out_sof, out_data
   );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel/Scharr edge detector with internal line buffers.
// Three-stage pipeline: window build, dx/dy, magnitude/mode/mask.
module sobel_stream #(
   parameter int WORD_SIZE  = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int KERNEL     = 1
) (
   input logic         clk,
   input logic         reset,
   sobel_stream_if.slave bus
);
   localparam int W  = WORD_SIZE;
   localparam int DW = W + 6;
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic signed [DW-1:0] KA = DW'((KERNEL != 0) ? 3 : 1);
   localparam logic signed [DW-1:0] KB = DW'((KERNEL != 0) ? 10 : 2);

   function automatic logic signed [DW-1:0] ext(input logic [W-1:0] p);
      return $signed({{(DW-W){1'b0}}, p});
   endfunction

   // ---------------- stage 1: position, line buffers, window ----------------
   logic [W-1:0]  line_a [IMG_WIDTH];
   logic [W-1:0]  line_b [IMG_WIDTH];
   logic [CW-1:0] col_cnt, pcol, col_nxt;
   logic [RW-1:0] row_cnt, prow, row_nxt;
   logic [W-1:0]  rd_a, rd_b;
   logic [W-1:0]  win [1:9];
   logic          v1, sof1, mask1;
   logic [1:0]    mode1;
   logic [W-1:0]  thr1;

   // sof overrides the running counters so this pixel is (0,0)
   always_comb begin
      pcol    = bus.sof ? '0 : col_cnt;
      prow    = bus.sof ? '0 : row_cnt;
      col_nxt = pcol + CW'(1);
      row_nxt = prow;
      if (pcol == COL_LAST) begin
         col_nxt = '0;
         row_nxt = (prow == ROW_LAST) ? '0 : prow + RW'(1);
      end
      rd_a = line_a[pcol];
      rd_b = line_b[pcol];
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         line_a[pcol] <= bus.in_data;
         line_b[pcol] <= rd_a;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_cnt <= '0;
         row_cnt <= '0;
         v1      <= 1'b0;
         sof1    <= 1'b0;
         mask1   <= 1'b1;
         mode1   <= '0;
         thr1    <= '0;
         for (int unsigned i = 1; i <= 9; i++) win[i] <= '0;
      end else begin
         v1   <= bus.in_valid;
         sof1 <= bus.in_valid & bus.sof;
         if (bus.in_valid) begin
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
            mask1   <= (prow < RW'(2)) || (pcol < CW'(2));
            mode1   <= bus.mode;
            thr1    <= bus.threshold;
            win[1]  <= win[2];
            win[2]  <= win[3];
            win[3]  <= rd_b;
            win[4]  <= win[5];
            win[5]  <= win[6];
            win[6]  <= rd_a;
            win[7]  <= win[8];
            win[8]  <= win[9];
            win[9]  <= bus.in_data;
         end
      end
   end

   // ---------------- stage 2: signed gradients ----------------
   logic signed [DW-1:0] dx_c, dy_c, dx, dy;
   logic                 v2, sof2, mask2;
   logic [1:0]           mode2;
   logic [W-1:0]         thr2;

   always_comb begin
      dx_c = KA * (ext(win[1]) + ext(win[7]) - ext(win[3]) - ext(win[9]))
           + KB * (ext(win[4]) - ext(win[6]));
      dy_c = KA * (ext(win[1]) + ext(win[3]) - ext(win[7]) - ext(win[9]))
           + KB * (ext(win[2]) - ext(win[8]));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v2    <= 1'b0;
         sof2  <= 1'b0;
         mask2 <= 1'b1;
         mode2 <= '0;
         thr2  <= '0;
         dx    <= '0;
         dy    <= '0;
      end else begin
         v2    <= v1;
         sof2  <= sof1;
         mask2 <= mask1;
         mode2 <= mode1;
         thr2  <= thr1;
         dx    <= dx_c;
         dy    <= dy_c;
      end
   end

   // ---------------- stage 3: magnitude, mode select, mask ----------------
   logic [DW-1:0] abs_dx, abs_dy;
   logic [DW:0]   sum, sel;
   logic [W-1:0]  sat, bin, result;
   logic          ov_q, osof_q;
   logic [W-1:0]  od_q;

   always_comb begin
      abs_dx = dx[DW-1] ? DW'(-dx) : DW'(dx);
      abs_dy = dy[DW-1] ? DW'(-dy) : DW'(dy);
      sum    = {1'b0, abs_dx} + {1'b0, abs_dy};
      case (mode2)
         2'd2:    sel = {1'b0, abs_dx};
         2'd3:    sel = {1'b0, abs_dy};
         default: sel = sum;
      endcase
      sat    = (sel > {{(DW+1-W){1'b0}}, {W{1'b1}}}) ? '1 : sel[W-1:0];
      // binary mode compares the unsaturated sum
      bin    = (sum > {{(DW+1-W){1'b0}}, thr2}) ? '1 : '0;
      result = mask2 ? '0 : ((mode2 == 2'd1) ? bin : sat);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ov_q   <= 1'b0;
         osof_q <= 1'b0;
         od_q   <= '0;
      end else begin
         ov_q   <= v2;
         osof_q <= sof2;
         od_q   <= result;
      end
   end

   assign bus.out_valid = ov_q;
   assign bus.out_sof   = osof_q;
   assign bus.out_data  = od_q;
endmodule
